// File: rtl/smi_pkg.sv
// smi_pkg: shared command codes, FSM state encodings and status record helper
package smi_pkg;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_STATUS = 8'h02;
    localparam logic [7:0] CMD_SWAP   = 8'h03;
    localparam logic [7:0] MAGIC_DEF  = 8'h45;
    localparam int STATUS_LEN = 4;
    localparam int PTR_W = $clog2(STATUS_LEN);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ADDR_H = 4'd1,
        ST_ADDR_L = 4'd2,
        ST_LEN_H  = 4'd3,
        ST_LEN_L  = 4'd4,
        ST_DATA   = 4'd5
    } state_t;

    function automatic logic [7:0] status_byte(
        input logic [PTR_W-1:0] idx,
        input logic [7:0]       magic,
        input logic             busy,
        input state_t           st,
        input logic [7:0]       err,
        input logic [7:0]       frames
    );
        return idx == PTR_W'(0) ? magic :
               idx == PTR_W'(1) ? {busy, 3'b000, st} :
               idx == PTR_W'(2) ? err : frames;
    endfunction
endpackage

// File: rtl/smi_status_rd.sv
// smi_status_rd: 4-byte status record served on SMI read strobes
module smi_status_rd
    import smi_pkg::*;
#(
    parameter logic [7:0] MAGIC = MAGIC_DEF
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       rd_req,
    input  logic       busy,
    input  state_t     state,
    input  logic [7:0] err_count,
    input  logic [7:0] frame_count,
    output logic [7:0] tx_data
);
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] nxt_ptr;

    assign nxt_ptr = rd_ptr + PTR_W'(1);

    // A STATUS command re-arms the record and wins over a coincident read
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            tx_data <= MAGIC;
        end else if (clr) begin
            rd_ptr  <= '0;
            tx_data <= MAGIC;
        end else if (rd_req) begin
            rd_ptr  <= nxt_ptr;
            tx_data <= status_byte(nxt_ptr, MAGIC, busy, state, err_count, frame_count);
        end
    end
endmodule

// File: rtl/smi_cmd_ctrl.sv
// smi_cmd_ctrl: parses the SMI write-byte stream into framebuffer writes,
// buffer swaps and status arming, with a mid-command idle timeout.
module smi_cmd_ctrl
    import smi_pkg::*;
#(
    parameter int          ADDR_W         = 16,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [7:0]  MAGIC          = 8'h45
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rd_req,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              fb_we,
    output logic              fb_swap,
    output logic              busy,
    output logic [7:0]        err_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state;
    logic [7:0]        addr_hi;
    logic [7:0]        len_hi;
    logic [7:0]        frame_count;
    logic [ADDR_W-1:0] cur_addr;
    logic [15:0]       remaining;
    logic [TW-1:0]     tmo;
    logic              cmd_idle;
    logic              tmo_hit;
    logic              bad_cmd;
    logic              err_inc;

    assign cmd_idle = rx_valid && state == ST_IDLE;
    assign tmo_hit  = state != ST_IDLE && !rx_valid && tmo == TW'(TIMEOUT_CYCLES - 1);
    assign bad_cmd  = cmd_idle && !(rx_data inside {CMD_WRITE, CMD_STATUS, CMD_SWAP});
    assign err_inc  = bad_cmd || tmo_hit;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            fb_we       <= 1'b0;
            fb_swap     <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
            err_count   <= '0;
            frame_count <= '0;
            addr_hi     <= '0;
            len_hi      <= '0;
            cur_addr    <= '0;
            remaining   <= '0;
            tmo         <= '0;
        end else begin
            fb_we   <= 1'b0;
            fb_swap <= 1'b0;
            tmo     <= (state == ST_IDLE || rx_valid || tmo_hit) ? '0 : tmo + TW'(1);
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (tmo_hit) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == CMD_WRITE) begin
                            state <= ST_ADDR_H;
                            busy  <= 1'b1;
                        end
                        if (rx_data == CMD_SWAP) begin
                            fb_swap     <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                        end
                    end
                    ST_ADDR_H: begin
                        addr_hi <= rx_data;
                        state   <= ST_ADDR_L;
                    end
                    ST_ADDR_L: begin
                        cur_addr <= ADDR_W'({addr_hi, rx_data});
                        state    <= ST_LEN_H;
                    end
                    ST_LEN_H: begin
                        len_hi <= rx_data;
                        state  <= ST_LEN_L;
                    end
                    ST_LEN_L: begin
                        remaining <= {len_hi, rx_data};
                        state     <= ({len_hi, rx_data} == 16'd0) ? ST_IDLE : ST_DATA;
                        busy      <= {len_hi, rx_data} != 16'd0;
                    end
                    ST_DATA: begin
                        fb_we     <= 1'b1;
                        fb_addr   <= cur_addr;
                        fb_data   <= rx_data;
                        cur_addr  <= cur_addr + ADDR_W'(1);
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    smi_status_rd #(.MAGIC(MAGIC)) u_status (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .clr         (cmd_idle && rx_data == CMD_STATUS),
        .rd_req      (rd_req),
        .busy        (busy),
        .state       (state),
        .err_count   (err_count),
        .frame_count (frame_count),
        .tx_data     (tx_data)
    );
endmodule

// File: doc/smi_cmd_ctrl.md
Name: smi_cmd_ctrl

Overview:
Command sequencer behind the SMI byte interface. It parses the Pi's write-byte stream into framed commands (framebuffer write, status-read arm, buffer swap) and drives a byte-wide framebuffer write port. It also serves a fixed 4-byte status record on SMI read strobes. It sits between the smi core and the LED framebuffer/output engine.

Parameters:
ADDR_W, 16, framebuffer byte-address width
TIMEOUT_CYCLES, 4096, idle CLK cycles allowed mid-command before abort
MAGIC, 8'h45, status record byte 0

Ports:
CLK  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
rx_data  in  8  byte written by the Pi (from smi core)
rx_valid  in  1  1-cycle strobe: rx_data valid
rd_req  in  1  1-cycle strobe: Pi read; tx_data is consumed
tx_data  out  8  byte presented to the smi core for the next read
fb_addr  out  ADDR_W  framebuffer write address
fb_data  out  8  framebuffer write data
fb_we  out  1  framebuffer write enable, 1 cycle per byte
fb_swap  out  1  1-cycle pulse: present back buffer
busy  out  1  high when the FSM is not in IDLE
err_count  out  8  saturating protocol-error counter

Behaviour:
- Reset (asynchronous, reset_n low): FSM=IDLE; fb_we=0; fb_swap=0; fb_addr=0; fb_data=0; busy=0; err_count=0; frame_count=0; rd_ptr=0; tx_data=MAGIC; timeout counter=0.
- Byte protocol, all multi-byte fields MSB first:
  - 8'h01 WRITE: addr_hi, addr_lo, len_hi, len_lo, then len data bytes.
  - 8'h02 STATUS: rd_ptr:=0; tx_data:=MAGIC on the next cycle.
  - 8'h03 SWAP: fb_swap high the cycle after rx_valid; frame_count+1, wraps at 8 bits.
  - Any other command byte: err_count+1, FSM stays IDLE.
- FSM states: IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA. Each transition occurs on rx_valid only.
  - IDLE--01-->ADDR_H-->ADDR_L-->LEN_H-->LEN_L.
  - LEN_L goes to DATA if len!=0. If len==0 it returns to IDLE with no write.
  - DATA: per rx_valid, fb_addr<=cur_addr, fb_data<=rx_data, fb_we=1 the next cycle (1-cycle latency). Then cur_addr+1 (wraps mod 2^ADDR_W) and remaining-1. The byte that brings remaining to 0 returns the FSM to IDLE.
  - ADDR_W < 16: address high bits are truncated.
- busy = (state != IDLE), registered with the state.
- Timeout: in any non-IDLE state, the counter increments each cycle without rx_valid and clears on rx_valid. At TIMEOUT_CYCLES: FSM→IDLE, err_count+1, no fb_we. The counter is held at 0 in IDLE.
- err_count saturates at 8'hFF.
- Status read path is independent of the FSM.
  - Record bytes: 0=MAGIC; 1={busy, 3'b0, state[3:0] encoding}; 2=err_count; 3=frame_count.
  - On rd_req: rd_ptr<=rd_ptr+1 mod 4; tx_data is updated to the new byte the cycle after.
  - Byte values are sampled when tx_data is loaded.
- Simultaneous rx_valid and rd_req: both are processed in the same cycle. An 02 command arriving with rd_req sets rd_ptr=0 (the 02 wins).
- Simultaneous timeout and error: a single increment.
- reset_n asserted mid-WRITE: the command is abandoned; no further fb_we.

Decomposition:
- Shared package smi_pkg holds: command codes CMD_WRITE=8'h01, CMD_STATUS=8'h02, CMD_SWAP=8'h03; state encodings; MAGIC default; status record length 4.
- One natural sub-module: smi_status_rd (rd_ptr, record mux, tx_data register). The top keeps the FSM and timeout.

Test Plan:
- Reset release, no stimulus: tx_data=8'h45, busy=0, err_count=0, fb_we never asserted.
- Send 01 00 10 00 03 AA BB CC: fb_we pulses 3 times at addresses 0x0010/11/12 with data AA/BB/CC, each 1 cycle after its rx_valid. busy drops after CC.
- Send 01 FF FF 00 02 11 22: writes land at 0xFFFF then 0x0000 (wrap). A length-0 write (01 00 00 00 00) produces no fb_we and returns to IDLE.
- Send 01 00 then idle for 4096 cycles: busy falls, err_count=1. Send 7F: err_count=2. Force 300 bad bytes: err_count holds at 8'hFF.
- Send 03 twice, then 02, then 5 rd_req: tx_data sequence 45, {busy/state}=00, err, 02, then wraps to 45. Exactly two fb_swap pulses seen.
- Drop reset_n mid-DATA after 1 of 4 bytes: outputs return to reset values immediately. Subsequent bytes produce no fb_we until a new 01 header.
